// File: rtl/dualport_ram.sv
// Synchronous single-address RAM with separate write-data and read-data paths.
// Storage is a register array so the asynchronous reset can clear every word.
module dualport_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_IDLE,
    OP_WRITE,
    OP_READ,
    OP_WRITE_THROUGH
  } op_e;

  op_e                  op;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;

  always_comb begin
    op = OP_NONE;
    if (cs) begin
      unique case ({wr, rd})
        2'b10:   op = OP_WRITE;
        2'b01:   op = OP_READ;
        2'b11:   op = OP_WRITE_THROUGH;
        default: op = OP_IDLE;
      endcase
    end
  end

  // Write-through forwards data_in so the output never shows the stale word.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    mem_d      = mem_q;
    data_out_d = data_out_q;
    unique case (op)
      OP_WRITE: mem_d[addr] = data_in;
      OP_READ:  data_out_d  = mem_q[addr];
      OP_WRITE_THROUGH: begin
        mem_d[addr] = data_in;
        data_out_d  = data_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is reset word by word; this is what forces a register array rather than block RAM.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      data_out_q <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignment so all flops sample pre-edge values.
      mem_q      <= mem_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_dualport_ram.sv
// Directed self-checking bench for dualport_ram: reset, gating, write-through,
// hold, back-to-back accesses and a full-depth sweep with a mid-sweep reset.
module tb_dualport_ram;

  localparam int AW = 8;
  localparam int DW = 4;

  logic          clk;
  logic          rst_n;
  logic          cs;
  logic          wr;
  logic          rd;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;

  int total;
  int bad;

  dualport_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (cs),
    .wr       (wr),
    .rd       (rd),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Drive one set of inputs across a rising edge; return 1ns after the edge.
  task automatic cyc(input logic c, input logic w, input logic r,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    cs      = c;
    wr      = w;
    rd      = r;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cs = 0; wr = 0; rd = 0; addr = '0; data_in = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (data_out !== 4'h0) begin
      bad++;
      $display("FAIL reset_state: data_out=%h expected=%h", data_out, 4'h0);
    end
    #3 rst_n = 1'b1;
    cyc(1, 1, 1, 8'h03, 4'h5);
    total++;
    if (data_out !== 4'h5) begin
      bad++;
      $display("FAIL reset_pre_wt: data_out=%h expected=%h", data_out, 4'h5);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (data_out !== 4'h0) begin
      bad++;
      $display("FAIL reset_async: data_out=%h expected=%h", data_out, 4'h0);
    end
    #2 rst_n = 1'b1;
    begin
      logic [AW-1:0] addrs [4];
      addrs = '{8'h00, 8'h01, 8'hFF, 8'h03};
      for (int i = 0; i < 4; i++) begin
        cyc(1, 0, 1, addrs[i], 4'hF);
        total++;
        if (data_out !== 4'h0) begin
          bad++;
          $display("FAIL reset_read addr=%h: data_out=%h expected=%h", addrs[i], data_out, 4'h0);
        end
      end
    end
  endtask

  task automatic test_basic_rw;
    cyc(1, 1, 0, 8'h01, 4'b0001);
    total++;
    if (data_out !== 4'h0) begin
      bad++;
      $display("FAIL basic_write_holds: data_out=%h expected=%h", data_out, 4'h0);
    end
    cyc(1, 1, 0, 8'h02, 4'b0010);
    cyc(1, 0, 1, 8'h01, 4'h0);
    total++;
    if (data_out !== 4'b0001) begin
      bad++;
      $display("FAIL basic_read1: data_out=%h expected=%h", data_out, 4'b0001);
    end
    cyc(1, 0, 1, 8'h02, 4'h0);
    total++;
    if (data_out !== 4'b0010) begin
      bad++;
      $display("FAIL basic_read2: data_out=%h expected=%h", data_out, 4'b0010);
    end
  endtask

  task automatic test_cs_gating;
    cyc(0, 1, 0, 8'h01, 4'hF);
    total++;
    if (data_out !== 4'b0010) begin
      bad++;
      $display("FAIL cs_write_gated: data_out=%h expected=%h", data_out, 4'b0010);
    end
    cyc(0, 0, 1, 8'h01, 4'h0);
    total++;
    if (data_out !== 4'b0010) begin
      bad++;
      $display("FAIL cs_read_gated: data_out=%h expected=%h", data_out, 4'b0010);
    end
    cyc(0, 1, 1, 8'h01, 4'hE);
    total++;
    if (data_out !== 4'b0010) begin
      bad++;
      $display("FAIL cs_wt_gated: data_out=%h expected=%h", data_out, 4'b0010);
    end
    cyc(1, 0, 1, 8'h01, 4'h0);
    total++;
    if (data_out !== 4'b0001) begin
      bad++;
      $display("FAIL cs_prior_value: data_out=%h expected=%h", data_out, 4'b0001);
    end
  endtask

  task automatic test_write_through;
    cyc(1, 1, 1, 8'h80, 4'hA);
    total++;
    if (data_out !== 4'hA) begin
      bad++;
      $display("FAIL wt_output: data_out=%h expected=%h", data_out, 4'hA);
    end
    cyc(1, 0, 1, 8'h00, 4'h0);
    total++;
    if (data_out !== 4'h0) begin
      bad++;
      $display("FAIL wt_other_addr: data_out=%h expected=%h", data_out, 4'h0);
    end
    cyc(1, 0, 1, 8'h80, 4'h0);
    total++;
    if (data_out !== 4'hA) begin
      bad++;
      $display("FAIL wt_readback: data_out=%h expected=%h", data_out, 4'hA);
    end
  endtask

  task automatic test_hold;
    logic [AW-1:0] addrs [5];
    addrs = '{8'h00, 8'h01, 8'h80, 8'hFF, 8'h55};
    cyc(1, 0, 1, 8'h02, 4'h0);
    total++;
    if (data_out !== 4'b0010) begin
      bad++;
      $display("FAIL hold_setup: data_out=%h expected=%h", data_out, 4'b0010);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, addrs[i], 4'h7);
      total++;
      if (data_out !== 4'b0010) begin
        bad++;
        $display("FAIL hold addr=%h: data_out=%h expected=%h", addrs[i], data_out, 4'b0010);
      end
    end
    cyc(1, 0, 1, 8'h55, 4'h0);
    total++;
    if (data_out !== 4'h0) begin
      bad++;
      $display("FAIL hold_no_write: data_out=%h expected=%h", data_out, 4'h0);
    end
  endtask

  task automatic test_back_to_back;
    cyc(1, 1, 0, 8'h10, 4'h3);
    cyc(1, 1, 0, 8'h11, 4'hC);
    cyc(1, 1, 0, 8'h12, 4'h9);
    cyc(1, 0, 1, 8'h12, 4'h0);
    total++;
    if (data_out !== 4'h9) begin
      bad++;
      $display("FAIL b2b_read_after_write: data_out=%h expected=%h", data_out, 4'h9);
    end
    cyc(1, 0, 1, 8'h10, 4'h0);
    total++;
    if (data_out !== 4'h3) begin
      bad++;
      $display("FAIL b2b_read_10: data_out=%h expected=%h", data_out, 4'h3);
    end
    cyc(1, 0, 1, 8'h11, 4'h0);
    total++;
    if (data_out !== 4'hC) begin
      bad++;
      $display("FAIL b2b_read_11: data_out=%h expected=%h", data_out, 4'hC);
    end
  endtask

  task automatic test_sweep;
    logic [AW-1:0] a;
    logic [DW-1:0] exp_v;
    for (int i = 0; i < 256; i++) begin
      a = AW'(i);
      cyc(1, 1, 0, a, a[3:0] ^ 4'h5);
    end
    for (int i = 0; i < 256; i++) begin
      a     = AW'(i);
      exp_v = a[3:0] ^ 4'h5;
      cyc(1, 0, 1, a, 4'h0);
      total++;
      if (data_out !== exp_v) begin
        bad++;
        $display("FAIL sweep_read addr=%h: data_out=%h expected=%h", a, data_out, exp_v);
      end
    end
    // Rewrite the pattern, then pulse reset partway through a readback.
    for (int i = 0; i < 256; i++) begin
      a = AW'(i);
      cyc(1, 1, 0, a, a[3:0] ^ 4'h5);
    end
    for (int i = 0; i < 128; i++) begin
      a = AW'(i);
      cyc(1, 0, 1, a, 4'h0);
    end
    cs = 1; wr = 1; rd = 0; addr = 8'h40; data_in = 4'hF;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a = AW'(i);
      cyc(1, 0, 1, a, 4'h0);
      total++;
      if (data_out !== 4'h0) begin
        bad++;
        $display("FAIL sweep_after_reset addr=%h: data_out=%h expected=%h", a, data_out, 4'h0);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic_rw();
    test_cs_gating();
    test_write_through();
    test_hold();
    test_back_to_back();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
